ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM pipeline register, data memory and load formatter for the 5-stage MIPS pipeline. Captures the ALU result, store data and control from EX, uses the ALU result as a byte address into a synchronous data memory, and writes byte/half/word stores. It then presents sign- or zero-extended load data, or the pass-through ALU result, through a MEM/WB register to write-back. It also exports EX/MEM-stage state to the forwarding unit.

## Interface
Parameters:
- NB_DATA, 32, data/address width
- NB_ADDR, 8, word-address bits; memory is 2^NB_ADDR 32-bit words
- NB_REG, 5, register-index width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_stall  in  1  hold both pipeline registers and suppress memory access
- i_flush  in  1  load a bubble into EX/MEM at next edge
- i_alu_result  in  NB_DATA  ALU result (byte address for loads/stores)
- i_store_data  in  NB_DATA  rt value for stores
- i_rd_addr  in  NB_REG  destination register
- i_reg_write  in  1  instruction writes a register
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_mem_size  in  2  00 byte, 01 half, 11 word; 10 treated as word
- i_mem_unsigned  in  1  zero-extend loads (LBU/LHU)
- i_mem_to_reg  in  1  write-back selects load data
- i_dbg_addr  in  NB_ADDR  debug word-address read port
- o_dbg_data  out  NB_DATA  asynchronous read of the word at i_dbg_addr
- o_fwd_alu_result  out  NB_DATA  EX/MEM-registered ALU result
- o_fwd_rd_addr  out  NB_REG  EX/MEM-registered rd
- o_fwd_reg_write  out  1  EX/MEM-registered reg_write, qualified by alignment
- o_wb_data  out  NB_DATA  write-back data
- o_wb_rd_addr  out  NB_REG  write-back register
- o_wb_reg_write  out  1  write-back enable
- o_mem_misaligned  out  1  one-cycle flag in WB for a misaligned access
- o_misaligned_sticky  out  1  set on any misaligned access, cleared only by reset

## Operation
- EX/MEM register captures all i_* data/control on an edge when i_stall=0.
  - i_flush=1: captures reg_write, mem_read, mem_write, mem_to_reg = 0 (bubble).
  - Flush has priority over stall.
- Word index = exmem_alu_result[NB_ADDR+1:2]; upper address bits ignored (wrap modulo memory size).
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠00.
  - Suppresses the memory write and clears reg_write into MEM/WB.
  - Raises o_mem_misaligned in WB and sets the sticky flag.
- Stores are little-endian with per-byte lane enables.
  - Byte: lane addr[1:0], data[7:0].
  - Half: lanes {2,3} if addr[1] else {0,1}, data[15:0].
  - Word: all lanes.
- The memory write occurs at the edge ending the MEM cycle, only if mem_write=1, aligned, and i_stall=0.
- Loads use a synchronous read, registered at the same edge; the memory output register holds while i_stall=1.
- MEM/WB captures rd, reg_write, mem_to_reg, addr[1:0], size, unsigned, and the ALU result.
- Load formatting is combinational from the memory output register and registered offset/size.
  - Byte: select lane addr[1:0], extend.
  - Half: select by addr[1], extend.
  - Extension is sign unless unsigned=1.
- o_wb_data = formatted load if mem_to_reg=1, else MEM/WB ALU result.
- Memory contents are not cleared by reset; o_dbg_data reads the array asynchronously.

## Timing
- Latency: inputs present in cycle N, EX/MEM at edge N+1, memory and MEM/WB at edge N+2; o_wb_* valid during cycle N+2.
- A store at edge N+2 is visible to a load whose MEM cycle is N+2 or later.
- Same-cycle read/write to the same address returns the old data; the hazard unit guarantees no such pair.
- Stall: all registers, including the sticky flag path and the memory output, hold for each stalled cycle; no write occurs.
- Reset, asynchronous, mid-operation: every register clears immediately and any in-flight store is lost.
  - All o_fwd_*, o_wb_*, o_mem_misaligned and o_misaligned_sticky read 0.
  - Memory contents are unchanged.
- Back-to-back stores and loads are sustained at one per cycle.

## Test plan
- Reset mid-stream with a store pending in EX/MEM -> all outputs 0 at once, target word unchanged via o_dbg_data.
- SW 0xDEADBEEF to addr 0x10, then LW from 0x10 -> o_wb_data=0xDEADBEEF, o_wb_reg_write=1 two cycles after LW input.
- SB 0x80 to addr 0x13, then LB and LBU from 0x13 -> word 0x10 = 0x80XXXXXX (other bytes preserved); o_wb_data 0xFFFFFF80 then 0x00000080.
- SH 0x8001 to addr 0x22, LH 0x22 -> 0xFFFF8001; LW at 0x21 -> o_wb_reg_write=0, o_mem_misaligned pulses 1 cycle, sticky=1.
- SW with i_stall=1 for 3 cycles, then i_flush on the following instruction -> write occurs exactly once after release; flushed instruction gives o_wb_reg_write=0.
- ADD result 0x1234 with mem_to_reg=0 -> o_fwd_alu_result=0x1234 the next cycle, o_wb_data=0x1234 the cycle after.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, byte-addressable synchronous data memory and
// MEM/WB register with load formatting for the 5-stage MIPS pipeline.
module ex_mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_store_data,
    input  logic [NB_REG-1:0]  i_rd_addr,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_mem_size,
    input  logic               i_mem_unsigned,
    input  logic               i_mem_to_reg,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic [NB_DATA-1:0] o_fwd_alu_result,
    output logic [NB_REG-1:0]  o_fwd_rd_addr,
    output logic               o_fwd_reg_write,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [NB_REG-1:0]  o_wb_rd_addr,
    output logic               o_wb_reg_write,
    output logic               o_mem_misaligned,
    output logic               o_misaligned_sticky
);

    logic [NB_DATA-1:0] exmem_alu_result;
    logic [NB_DATA-1:0] exmem_store_data;
    logic [NB_REG-1:0]  exmem_rd_addr;
    logic               exmem_reg_write;
    logic               exmem_mem_read;
    logic               exmem_mem_write;
    logic [1:0]         exmem_mem_size;
    logic               exmem_mem_unsigned;
    logic               exmem_mem_to_reg;

    logic [NB_DATA-1:0] mem [2**NB_ADDR];
    logic [NB_DATA-1:0] mem_rdata;

    logic [NB_DATA-1:0] wb_alu_result;
    logic [NB_REG-1:0]  wb_rd_addr;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;
    logic [1:0]         wb_offset;
    logic [1:0]         wb_size;
    logic               wb_unsigned;
    logic               wb_misaligned;
    logic               misaligned_sticky;

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         byte_off;
    logic               misaligned;
    logic [3:0]         byte_en;
    logic [NB_DATA-1:0] wdata;
    logic               do_write;
    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic [NB_DATA-1:0] load_data;

    // A flush loads a bubble even while stalled; data fields ride along harmlessly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            exmem_alu_result   <= '0;
            exmem_store_data   <= '0;
            exmem_rd_addr      <= '0;
            exmem_reg_write    <= 1'b0;
            exmem_mem_read     <= 1'b0;
            exmem_mem_write    <= 1'b0;
            exmem_mem_size     <= 2'b00;
            exmem_mem_unsigned <= 1'b0;
            exmem_mem_to_reg   <= 1'b0;
        end else if (i_flush || !i_stall) begin
            exmem_alu_result   <= i_alu_result;
            exmem_store_data   <= i_store_data;
            exmem_rd_addr      <= i_rd_addr;
            exmem_reg_write    <= i_reg_write & ~i_flush;
            exmem_mem_read     <= i_mem_read & ~i_flush;
            exmem_mem_write    <= i_mem_write & ~i_flush;
            exmem_mem_size     <= i_mem_size;
            exmem_mem_unsigned <= i_mem_unsigned;
            exmem_mem_to_reg   <= i_mem_to_reg & ~i_flush;
        end
    end

    assign word_idx = exmem_alu_result[NB_ADDR+1:2];
    assign byte_off = exmem_alu_result[1:0];

    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b1111;
        wdata      = exmem_store_data;
        case (exmem_mem_size)
            2'b00: begin
                byte_en = 4'b0001 << byte_off;
                wdata   = {4{exmem_store_data[7:0]}};
            end
            2'b01: begin
                misaligned = byte_off[0];
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{exmem_store_data[15:0]}};
            end
            default: misaligned = (byte_off != 2'b00);
        endcase
        misaligned = misaligned & (exmem_mem_read | exmem_mem_write);
    end

    assign do_write = exmem_mem_write & ~misaligned & ~i_stall & ~i_rst;

    // Data memory has no reset so its contents survive a pipeline reset.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_dbg_data = mem[i_dbg_addr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_rdata         <= '0;
            wb_alu_result     <= '0;
            wb_rd_addr        <= '0;
            wb_reg_write      <= 1'b0;
            wb_mem_to_reg     <= 1'b0;
            wb_offset         <= 2'b00;
            wb_size           <= 2'b00;
            wb_unsigned       <= 1'b0;
            wb_misaligned     <= 1'b0;
            misaligned_sticky <= 1'b0;
        end else if (!i_stall) begin
            mem_rdata         <= mem[word_idx];
            wb_alu_result     <= exmem_alu_result;
            wb_rd_addr        <= exmem_rd_addr;
            wb_reg_write      <= exmem_reg_write & ~misaligned;
            wb_mem_to_reg     <= exmem_mem_to_reg;
            wb_offset         <= byte_off;
            wb_size           <= exmem_mem_size;
            wb_unsigned       <= exmem_mem_unsigned;
            wb_misaligned     <= misaligned;
            misaligned_sticky <= misaligned_sticky | misaligned;
        end
    end

    assign lane_byte = mem_rdata[{wb_offset, 3'b000} +: 8];
    assign lane_half = wb_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (wb_size)
            2'b00:   load_data = wb_unsigned ? {{(NB_DATA-8){1'b0}}, lane_byte}
                                             : {{(NB_DATA-8){lane_byte[7]}}, lane_byte};
            2'b01:   load_data = wb_unsigned ? {{(NB_DATA-16){1'b0}}, lane_half}
                                             : {{(NB_DATA-16){lane_half[15]}}, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    assign o_wb_data           = wb_mem_to_reg ? load_data : wb_alu_result;
    assign o_wb_rd_addr        = wb_rd_addr;
    assign o_wb_reg_write      = wb_reg_write;
    assign o_mem_misaligned    = wb_misaligned;
    assign o_misaligned_sticky = misaligned_sticky;
    assign o_fwd_alu_result    = exmem_alu_result;
    assign o_fwd_rd_addr       = exmem_rd_addr;
    assign o_fwd_reg_write     = exmem_reg_write & ~misaligned;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized bench for ex_mem_stage, checked against a
// byte-array memory model that tracks which instruction sits in each stage.
module tb_ex_mem_stage;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 8;
    localparam int NB_REG  = 5;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_stall;
    logic               i_flush;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] i_store_data;
    logic [NB_REG-1:0]  i_rd_addr;
    logic               i_reg_write;
    logic               i_mem_read;
    logic               i_mem_write;
    logic [1:0]         i_mem_size;
    logic               i_mem_unsigned;
    logic               i_mem_to_reg;
    logic [NB_ADDR-1:0] i_dbg_addr;
    logic [NB_DATA-1:0] o_dbg_data;
    logic [NB_DATA-1:0] o_fwd_alu_result;
    logic [NB_REG-1:0]  o_fwd_rd_addr;
    logic               o_fwd_reg_write;
    logic [NB_DATA-1:0] o_wb_data;
    logic [NB_REG-1:0]  o_wb_rd_addr;
    logic               o_wb_reg_write;
    logic               o_mem_misaligned;
    logic               o_misaligned_sticky;

    ex_mem_stage #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_alu_result(i_alu_result), .i_store_data(i_store_data),
        .i_rd_addr(i_rd_addr), .i_reg_write(i_reg_write),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
        .i_mem_to_reg(i_mem_to_reg), .i_dbg_addr(i_dbg_addr),
        .o_dbg_data(o_dbg_data), .o_fwd_alu_result(o_fwd_alu_result),
        .o_fwd_rd_addr(o_fwd_rd_addr), .o_fwd_reg_write(o_fwd_reg_write),
        .o_wb_data(o_wb_data), .o_wb_rd_addr(o_wb_rd_addr),
        .o_wb_reg_write(o_wb_reg_write), .o_mem_misaligned(o_mem_misaligned),
        .o_misaligned_sticky(o_misaligned_sticky)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r, uns;
        logic [1:0]  size;
    } instr_t;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: byte-addressed memory, the instruction in MEM, and WB expectations.
    logic [7:0]  mb [1024];
    instr_t      m_ex;
    logic [31:0] e_wb_data;
    logic [4:0]  e_wb_rd;
    logic        e_wb_rw, e_mis, e_sticky, e_data_valid;

    function automatic instr_t mk(logic [31:0] alu, logic [31:0] sd, logic [4:0] rd,
                                  logic rw, logic mr, logic mw, logic m2r, logic uns,
                                  logic [1:0] size);
        instr_t t;
        t.alu = alu; t.sd = sd; t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw;
        t.m2r = m2r; t.uns = uns; t.size = size;
        return t;
    endfunction

    function automatic instr_t op_nop();
        return mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic instr_t op_alu(logic [31:0] v, logic [4:0] rd);
        return mk(v, 32'h0, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic instr_t op_store(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        return mk(a, d, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sz);
    endfunction
    function automatic instr_t op_load(logic [31:0] a, logic [1:0] sz, logic uns, logic [4:0] rd);
        return mk(a, 32'h0, rd, 1'b1, 1'b1, 1'b0, 1'b1, uns, sz);
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_mis(instr_t t);
        if (!(t.mr || t.mw)) return 1'b0;
        return (int'(t.alu[9:0]) % nbytes(t.size)) != 0;
    endfunction

    function automatic logic [31:0] mword(int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    task automatic model_reset();
        m_ex = op_nop();
        e_wb_data = 32'h0; e_wb_rd = 5'd0; e_wb_rw = 1'b0;
        e_mis = 1'b0; e_sticky = 1'b0; e_data_valid = 1'b1;
    endtask

    task automatic model_edge(instr_t in, logic stall, logic flush);
        int a, n;
        logic mis;
        logic [31:0] val;
        if (!stall) begin
            a   = int'(m_ex.alu[9:0]);
            n   = nbytes(m_ex.size);
            mis = is_mis(m_ex);
            val = 32'h0;
            if (m_ex.mr && !mis) begin
                for (int i = 0; i < n; i++) val = val | (32'(mb[a+i]) << (8*i));
                if (n < 4 && !m_ex.uns && val[8*n-1]) val = val - (32'd1 << (8*n));
            end
            e_wb_data    = m_ex.m2r ? val : m_ex.alu;
            e_data_valid = !(m_ex.m2r && mis);
            if (m_ex.mw && !mis) begin
                for (int i = 0; i < n; i++) mb[a+i] = m_ex.sd[8*i +: 8];
            end
            e_wb_rw = m_ex.rw && !mis;
            e_wb_rd = m_ex.rd;
            e_mis   = mis;
            if (mis) e_sticky = 1'b1;
        end
        if (flush) begin
            m_ex = in;
            m_ex.rw = 1'b0; m_ex.mr = 1'b0; m_ex.mw = 1'b0; m_ex.m2r = 1'b0;
        end else if (!stall) begin
            m_ex = in;
        end
    endtask

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("fwd_alu", o_fwd_alu_result, m_ex.alu);
        checkOutput("fwd_rd", 32'(o_fwd_rd_addr), 32'(m_ex.rd));
        checkOutput("fwd_rw", 32'(o_fwd_reg_write), 32'(m_ex.rw && !is_mis(m_ex)));
        checkOutput("wb_rd", 32'(o_wb_rd_addr), 32'(e_wb_rd));
        checkOutput("wb_rw", 32'(o_wb_reg_write), 32'(e_wb_rw));
        if (e_data_valid) checkOutput("wb_data", o_wb_data, e_wb_data);
        checkOutput("mis", 32'(o_mem_misaligned), 32'(e_mis));
        checkOutput("sticky", 32'(o_misaligned_sticky), 32'(e_sticky));
    endtask

    task automatic checkWord(string tag, int w);
        i_dbg_addr = NB_ADDR'(w);
        #1;
        checkOutput(tag, o_dbg_data, mword(w));
    endtask

    task automatic drive(instr_t t, logic stall, logic flush);
        i_alu_result = t.alu; i_store_data = t.sd; i_rd_addr = t.rd;
        i_reg_write = t.rw; i_mem_read = t.mr; i_mem_write = t.mw;
        i_mem_to_reg = t.m2r; i_mem_unsigned = t.uns; i_mem_size = t.size;
        i_stall = stall; i_flush = flush;
    endtask

    task automatic applyStimulus(instr_t t, logic stall, logic flush);
        drive(t, stall, flush);
        @(posedge i_clk);
        model_edge(t, stall, flush);
        #1;
        checkAll();
    endtask

    function automatic instr_t rand_instr();
        logic [31:0] r, addr;
        logic [1:0]  sz;
        int k;
        r    = $urandom();
        addr = {r[31:10], 4'b0000, r[5:0]};
        sz   = 2'($urandom_range(0, 3));
        k    = $urandom_range(0, 2);
        if (k == 0) return op_alu($urandom(), 5'($urandom_range(0, 31)));
        if (k == 1) return op_store(addr, $urandom(), sz);
        return op_load(addr, sz, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    endfunction

    initial begin
        logic [31:0] saved;
        i_rst = 1'b1;
        i_dbg_addr = '0;
        drive(op_nop(), 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        checkAll();
        checkOutput("rst_wb_data", o_wb_data, 32'h0);
        i_rst = 1'b0;

        // Word store then load back.
        applyStimulus(op_store(32'h30, 32'h0, 2'b11), 1'b0, 1'b0);
        applyStimulus(op_store(32'h10, 32'hDEADBEEF, 2'b11), 1'b0, 1'b0);
        applyStimulus(op_load(32'h10, 2'b11, 1'b0, 5'd3), 1'b0, 1'b0);
        applyStimulus(op_nop(), 1'b0, 1'b0);
        checkOutput("lw_data", o_wb_data, 32'hDEADBEEF);
        checkOutput("lw_rw", 32'(o_wb_reg_write), 32'd1);

        // Byte store, signed and unsigned byte loads.
        applyStimulus(op_store(32'h13, 32'h00000080, 2'b00), 1'b0, 1'b0);
        applyStimulus(op_load(32'h13, 2'b00, 1'b0, 5'd4), 1'b0, 1'b0);
        applyStimulus(op_load(32'h13, 2'b00, 1'b1, 5'd5), 1'b0, 1'b0);
        checkOutput("lb_data", o_wb_data, 32'hFFFFFF80);
        applyStimulus(op_nop(), 1'b0, 1'b0);
        checkOutput("lbu_data", o_wb_data, 32'h00000080);
        checkWord("sb_word", 4);
        checkOutput("sb_word_const", o_dbg_data, 32'h80ADBEEF);

        // Half store and load, then misaligned word load.
        applyStimulus(op_store(32'h22, 32'h00008001, 2'b01), 1'b0, 1'b0);
        applyStimulus(op_load(32'h22, 2'b01, 1'b0, 5'd6), 1'b0, 1'b0);
        applyStimulus(op_load(32'h21, 2'b11, 1'b0, 5'd7), 1'b0, 1'b0);
        checkOutput("lh_data", o_wb_data, 32'hFFFF8001);
        checkOutput("mis_fwd_rw", 32'(o_fwd_reg_write), 32'd0);
        applyStimulus(op_nop(), 1'b0, 1'b0);
        checkOutput("mis_pulse", 32'(o_mem_misaligned), 32'd1);
        checkOutput("mis_rw", 32'(o_wb_reg_write), 32'd0);
        applyStimulus(op_nop(), 1'b0, 1'b0);
        checkOutput("mis_drop", 32'(o_mem_misaligned), 32'd0);
        checkOutput("mis_sticky", 32'(o_misaligned_sticky), 32'd1);

        // Stalled store, then flush of the following instruction.
        applyStimulus(op_store(32'h30, 32'h11223344, 2'b11), 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(op_alu(32'h55, 5'd8), 1'b1, 1'b0);
            checkWord("stall_nowrite", 12);
            checkOutput("stall_nowrite_const", o_dbg_data, 32'h0);
        end
        applyStimulus(op_alu(32'h55, 5'd8), 1'b0, 1'b1);
        checkWord("stall_write", 12);
        checkOutput("stall_write_const", o_dbg_data, 32'h11223344);
        applyStimulus(op_nop(), 1'b0, 1'b0);
        checkOutput("flush_rw", 32'(o_wb_reg_write), 32'd0);

        // ALU pass-through.
        applyStimulus(op_alu(32'h1234, 5'd9), 1'b0, 1'b0);
        checkOutput("add_fwd", o_fwd_alu_result, 32'h1234);
        applyStimulus(op_nop(), 1'b0, 1'b0);
        checkOutput("add_wb", o_wb_data, 32'h1234);

        // Initialise the random region, then randomized traffic.
        for (int w = 0; w < 16; w++) applyStimulus(op_store(32'(4*w), $urandom(), 2'b11), 1'b0, 1'b0);
        applyStimulus(op_nop(), 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            applyStimulus(rand_instr(), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
            checkWord("rand_word", $urandom_range(0, 15));
        end

        // Asynchronous reset with a store pending in EX/MEM.
        applyStimulus(op_store(32'h14, 32'hCAFEF00D, 2'b11), 1'b0, 1'b0);
        saved = mword(5);
        drive(op_nop(), 1'b0, 1'b0);
        #3;
        i_rst = 1'b1;
        #1;
        model_reset();
        checkAll();
        checkOutput("rst_fwd_alu", o_fwd_alu_result, 32'h0);
        checkOutput("rst_wb_data", o_wb_data, 32'h0);
        checkOutput("rst_sticky", 32'(o_misaligned_sticky), 32'd0);
        @(posedge i_clk);
        #1;
        checkWord("rst_word", 5);
        checkOutput("rst_word_saved", o_dbg_data, saved);
        i_rst = 1'b0;
        applyStimulus(op_nop(), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
